// File: rtl/lzc_pipe.sv
// lzc_pipe: two-stage leading-zero counter with valid/ready handshake.
// S1 counts leading zeros of the upper and lower halves in parallel.
// S2 merges the two half counts into the final count and zero flag.
// The S2 registers drive the out_* ports directly.
module lzc_pipe #(
    parameter int N       = 32,
    parameter int D_WIDTH = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in_x,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       out_x,
    output logic [D_WIDTH-1:0] out_d,
    output logic               out_zero
);

    localparam int L  = N / 2;   // split point; lower field is [L-1:0]
    localparam int UW = N - L;   // upper field width, bits [N-1:L]

    typedef struct packed {
        logic [N-1:0]       x;
        logic [D_WIDTH-1:0] lz_hi;
        logic [D_WIDTH-1:0] lz_lo;
        logic               zero_hi;
        logic               zero_lo;
    } s1_t;

    typedef struct packed {
        logic [N-1:0]       x;
        logic [D_WIDTH-1:0] d;
        logic               zero;
    } s2_t;

    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    s1_t  s1_q, s1_d, s1_new;
    s2_t  s2_q, s2_d, s2_new;
    logic adv1, adv2;

    // Handshake: a stage may take new data when it is empty or its successor advances.
    always_comb begin
        adv2     = !s2_valid_q || out_ready;
        adv1     = !s1_valid_q || adv2;
        in_ready = adv1;
    end

    // Per-half leading-zero counts; the highest set bit is the last match, so it wins.
    always_comb begin
        s1_new         = '0;
        s1_new.x       = in_x;
        s1_new.zero_hi = ~|in_x[N-1:L];
        s1_new.zero_lo = ~|in_x[L-1:0];
        for (int i = L; i < N; i++) begin
            if (in_x[i]) s1_new.lz_hi = D_WIDTH'(N - 1 - i);
        end
        for (int i = 0; i < L; i++) begin
            if (in_x[i]) s1_new.lz_lo = D_WIDTH'(L - 1 - i);
        end
    end

    // Merge half counts; the lower count is offset by the upper field width.
    always_comb begin
        s2_new      = '0;
        s2_new.x    = s1_q.x;
        s2_new.zero = s1_q.zero_hi && s1_q.zero_lo;
        if (!s1_q.zero_hi)
            s2_new.d = s1_q.lz_hi;
        else if (!s1_q.zero_lo)
            s2_new.d = D_WIDTH'(UW) + s1_q.lz_lo;
        else
            s2_new.d = '0;
    end

    // Next-state for both stages; data loads only when a valid item actually moves in,
    // which keeps out_* quiet while the pipe is empty and frozen while stalled.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) s2_d = s2_new;
        end
        if (adv1) begin
            s1_valid_d = in_valid;
            if (in_valid) s1_d = s1_new;
        end
    end

    // Stage registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

    // Outputs come straight from the S2 registers.
    always_comb begin
        out_valid = s2_valid_q;
        out_x     = s2_q.x;
        out_d     = s2_q.d;
        out_zero  = s2_q.zero;
    end

endmodule

// File: tb/tb_lzc_pipe.sv
// tb_lzc_pipe: directed and randomized checks of lzc_pipe at N=32 and N=5.
// Reference count is derived from the operand's magnitude: n - bitlength(x).
module tb_lzc_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // N = 32 instance
    logic        iv, ir, ov, ordy, oz;
    logic [31:0] ix, ox;
    logic [4:0]  od;

    // N = 5 instance
    logic        iv5, ir5, ov5, or5, oz5;
    logic [4:0]  ix5, ox5;
    logic [2:0]  od5;

    lzc_pipe #(.N(32)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv), .in_ready(ir), .in_x(ix),
        .out_valid(ov), .out_ready(ordy), .out_x(ox), .out_d(od), .out_zero(oz)
    );

    lzc_pipe #(.N(5)) dut5 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv5), .in_ready(ir5), .in_x(ix5),
        .out_valid(ov5), .out_ready(or5), .out_x(ox5), .out_d(od5), .out_zero(oz5)
    );

    int ncmp = 0;
    int nerr = 0;

    // Operands accepted but not yet consumed, oldest first.
    logic [31:0] q[$];
    logic [4:0]  q5[$];

    function automatic int ref_lz(longint unsigned x, int n);
        if (x == 0) return 0;
        return n - $clog2(x + 1);
    endfunction

    task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the scoreboard mid-cycle, then cross the edge.
    // Holding-capacity model: the block refuses input only with two items held and no drain.
    task automatic cycle(output bit acc);
        logic [31:0] e;
        logic [4:0]  e5;
        @(negedge clk);
        chk("in_ready", ir, (q.size() < 2) || ordy);
        if (ov) begin
            chk("valid_has_pending", q.size() > 0, 1);
            if (q.size() > 0) begin
                e = q[0];
                chk("out_x", ox, e);
                chk("out_d", od, ref_lz(e, 32));
                chk("out_zero", oz, e == 0);
                if (ordy) void'(q.pop_front());
            end
        end
        acc = iv && ir;
        if (acc) q.push_back(ix);

        chk("in_ready5", ir5, (q5.size() < 2) || or5);
        if (ov5) begin
            chk("valid5_has_pending", q5.size() > 0, 1);
            if (q5.size() > 0) begin
                e5 = q5[0];
                chk("out_x5", ox5, e5);
                chk("out_d5", od5, ref_lz(e5, 5));
                chk("out_zero5", oz5, e5 == 0);
                chk("out_d5_max", od5 <= 3'd4, 1);
                if (or5) void'(q5.pop_front());
            end
        end
        if (iv5 && ir5) q5.push_back(ix5);
        @(posedge clk);
        #1;
    endtask

    // One operand with out_ready=1: absent after the accepting edge, present after the
    // next edge, consumed at the second edge after acceptance.
    task automatic single(input logic [31:0] x, input int exp_d, input bit exp_z);
        bit a;
        ordy = 1'b1;
        iv   = 1'b1;
        ix   = x;
        cycle(a);
        chk("single_accept", a, 1);
        iv = 1'b0;
        chk("single_early", ov, 0);
        cycle(a);
        chk("single_valid", ov, 1);
        chk("single_x", ox, x);
        chk("single_d", od, exp_d);
        chk("single_zero", oz, exp_z);
        cycle(a);
        chk("single_drained", q.size(), 0);
    endtask

    task automatic drain(input string tag);
        bit a;
        iv   = 1'b0;
        iv5  = 1'b0;
        ordy = 1'b1;
        or5  = 1'b1;
        for (int k = 0; k < 20 && (q.size() > 0 || q5.size() > 0); k++) cycle(a);
        chk(tag, q.size() + q5.size(), 0);
    endtask

    initial begin
        bit a;
        int sent;
        bit saw_block;

        rst_n = 1'b0;
        iv = 1'b0; ix = '0; ordy = 1'b1;
        iv5 = 1'b0; ix5 = '0; or5 = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_out_valid", ov, 0);
        chk("rst_out_x", ox, 0);
        chk("rst_out_d", od, 0);
        chk("rst_out_zero", oz, 0);
        chk("rst_in_ready", ir, 1);
        chk("rst_out_valid5", ov5, 0);
        rst_n = 1'b1;

        // Directed single operands
        single(32'h0001_0000, 15, 1'b0);
        single(32'h8000_0000, 0, 1'b0);
        single(32'h0000_0001, 31, 1'b0);
        single(32'h0000_FFFF, 16, 1'b0);
        single(32'h0000_0000, 0, 1'b1);

        // 64 back-to-back random operands with no backpressure
        ordy = 1'b1;
        for (int i = 0; i < 64; i++) begin
            iv = 1'b1;
            ix = $urandom >> $urandom_range(0, 31);
            cycle(a);
            chk("stream_accept", a, 1);
            if (i >= 1) chk("stream_out_valid", ov, 1);
        end
        drain("stream_drain");

        // Five operands with out_ready low for cycles 3..6
        sent = 0;
        saw_block = 1'b0;
        for (int c = 1; c <= 30 && (sent < 5 || q.size() > 0); c++) begin
            ordy = !(c >= 3 && c <= 6);
            iv   = (sent < 5);
            ix   = $urandom;
            if (!ir) saw_block = 1'b1;
            cycle(a);
            if (a) sent++;
        end
        chk("bp_sent", sent, 5);
        chk("bp_blocked", saw_block, 1);
        drain("bp_drain");

        // Random traffic on both instances
        for (int i = 0; i < 10000; i++) begin
            iv   = $urandom_range(0, 1);
            ordy = $urandom_range(0, 3) != 0;
            ix   = $urandom >> $urandom_range(0, 32);
            iv5  = $urandom_range(0, 1);
            or5  = $urandom_range(0, 1);
            ix5  = 5'($urandom);
            cycle(a);
        end
        drain("rand_drain");

        // Reset with both stages full
        ordy = 1'b0;
        iv   = 1'b1;
        ix   = 32'h1234_5678;
        cycle(a);
        ix   = 32'h0000_0F00;
        cycle(a);
        chk("pre_rst_full", q.size(), 2);
        iv    = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        chk("midrst_out_valid", ov, 0);
        chk("midrst_out_x", ox, 0);
        chk("midrst_out_d", od, 0);
        chk("midrst_out_zero", oz, 0);
        chk("midrst_in_ready", ir, 1);
        rst_n = 1'b1;
        single(32'h0000_0100, 23, 1'b0);

        // N=5: every operand value, back to back
        or5 = 1'b1;
        for (int v = 0; v < 32; v++) begin
            iv5 = 1'b1;
            ix5 = 5'(v);
            cycle(a);
        end
        drain("n5_drain");

        // N=5 spot values
        iv5 = 1'b1; ix5 = 5'b00001; cycle(a); iv5 = 1'b0; cycle(a);
        chk("n5_one_d", od5, 4);
        cycle(a);
        iv5 = 1'b1; ix5 = 5'b00100; cycle(a); iv5 = 1'b0; cycle(a);
        chk("n5_four_d", od5, 2);
        cycle(a);
        iv5 = 1'b1; ix5 = 5'b00000; cycle(a); iv5 = 1'b0; cycle(a);
        chk("n5_zero_flag", oz5, 1);
        chk("n5_zero_d", od5, 0);
        drain("n5_final_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
